// File: rtl/memory_multiport.sv
// Multi-port memory: one write port and R_PORTS read ports serialised onto a single-port array.
// Define MEMORY_ADDR_CHECK_EN to add the addr_err output flagging out-of-range accesses.
module memory_multiport #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter logic [WORD_SIZE-1:0] WORD_INIT = '0,
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned MEMORY_QTY   = 16,
  parameter int unsigned R_PORTS      = 2,
  parameter int unsigned WAIT_SIZE    = 2,
  parameter int unsigned READ_WAIT    = 0,
  parameter int unsigned WRITE_WAIT   = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            w_en,
  input  logic [ADDRESS_SIZE-1:0]         w_addr,
  input  logic [WORD_SIZE-1:0]            w_data,
  output logic                            w_ready,
  input  logic [R_PORTS-1:0]              r_en,
  input  logic [R_PORTS*ADDRESS_SIZE-1:0] r_addr,
  output logic [R_PORTS*WORD_SIZE-1:0]    r_data,
  output logic [R_PORTS-1:0]              r_ready
`ifdef MEMORY_ADDR_CHECK_EN
  ,
  output logic                            addr_err
`endif
);

  localparam int unsigned PTR_W = (R_PORTS > 1) ? $clog2(R_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t                  state;
  logic [WAIT_SIZE-1:0]    cnt;
  logic                    w_armed;
  logic [R_PORTS-1:0]      r_armed;
  logic                    w_req_q;
  logic [R_PORTS-1:0]      r_req_q;
  logic                    last_write;
  logic                    grant_write;
  logic [PTR_W-1:0]        grant_port;
  logic [PTR_W-1:0]        ptr;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    data_q;

  logic [WORD_SIZE-1:0] mem [MEMORY_QTY] = '{default: WORD_INIT};

  logic                 in_range;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] rd_word;
  logic                 w_pick;
  logic                 rr_found;
  logic [PTR_W-1:0]     rr_port;
  logic [PTR_W-1:0]     rr_next;
  logic [PTR_W-1:0]     sel;

  assign in_range = ({1'b0, addr_q} < (ADDRESS_SIZE+1)'(MEMORY_QTY));
  assign mem_we   = (state == S_ACCESS) && grant_write && in_range;
  assign rd_word  = in_range ? mem[addr_q] : WORD_INIT;

  // A write only beats reads when the previous grant was not itself a write.
  assign w_pick = w_req_q && !(last_write && (|r_req_q));

  always_comb begin
    rr_found = 1'b0;
    rr_port  = '0;
    rr_next  = '0;
    sel      = '0;
    for (int unsigned k = 0; k < R_PORTS; k++) begin
      sel = PTR_W'((32'(ptr) + k) % R_PORTS);
      if (!rr_found && r_req_q[sel]) begin
        rr_found = 1'b1;
        rr_port  = sel;
        rr_next  = PTR_W'((32'(sel) + 1) % R_PORTS);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[addr_q] <= data_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      w_ready     <= 1'b0;
      r_ready     <= '0;
      r_data      <= '0;
      ptr         <= '0;
      w_armed     <= 1'b1;
      r_armed     <= '1;
      w_req_q     <= 1'b0;
      r_req_q     <= '0;
      last_write  <= 1'b0;
      grant_write <= 1'b0;
      grant_port  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
`ifdef MEMORY_ADDR_CHECK_EN
      addr_err    <= 1'b0;
`endif
    end else begin
      w_ready <= 1'b0;
      r_ready <= '0;
`ifdef MEMORY_ADDR_CHECK_EN
      addr_err <= 1'b0;
`endif
      // Requests pass through a sampling register; the ACCESS branch below overrides it for the completing port.
      if (!w_en) w_armed <= 1'b1;
      w_req_q <= w_en & w_armed;
      for (int unsigned k = 0; k < R_PORTS; k++) begin
        if (!r_en[k]) r_armed[k] <= 1'b1;
        r_req_q[k] <= r_en[k] & r_armed[k];
      end

      case (state)
        S_IDLE: begin
          if (w_pick) begin
            grant_write <= 1'b1;
            last_write  <= 1'b1;
            addr_q      <= w_addr;
            data_q      <= w_data;
            cnt         <= WAIT_SIZE'(WRITE_WAIT);
            state       <= (WRITE_WAIT != 0) ? S_WAIT : S_ACCESS;
          end else if (rr_found) begin
            grant_write <= 1'b0;
            last_write  <= 1'b0;
            grant_port  <= rr_port;
            ptr         <= rr_next;
            addr_q      <= r_addr[rr_port*ADDRESS_SIZE +: ADDRESS_SIZE];
            cnt         <= WAIT_SIZE'(READ_WAIT);
            state       <= (READ_WAIT != 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == WAIT_SIZE'(1)) state <= S_ACCESS;
        end
        S_ACCESS: begin
          state <= S_IDLE;
          if (grant_write) begin
            w_ready <= 1'b1;
            w_armed <= 1'b0;
            w_req_q <= 1'b0;
          end else begin
            r_ready[grant_port]                          <= 1'b1;
            r_data[grant_port*WORD_SIZE +: WORD_SIZE]    <= rd_word;
            r_armed[grant_port]                          <= 1'b0;
            r_req_q[grant_port]                          <= 1'b0;
          end
`ifdef MEMORY_ADDR_CHECK_EN
          addr_err <= !in_range;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_multiport.sv
// Randomised self-checking bench for memory_multiport against a transaction-level array model.
// Checks addr_err as well when MEMORY_ADDR_CHECK_EN is defined.
module tb_memory_multiport;
  localparam int unsigned WS   = 8;
  localparam int unsigned AS   = 4;
  localparam int unsigned QTY  = 12;
  localparam int unsigned RP   = 2;
  localparam int unsigned WSZ  = 2;
  localparam int unsigned RW   = 3;
  localparam int unsigned WW   = 2;
  localparam logic [WS-1:0] INIT = 8'h5C;

  logic             clock = 1'b0;
  logic             reset;
  logic             w_en;
  logic [AS-1:0]    w_addr;
  logic [WS-1:0]    w_data;
  logic             w_ready;
  logic [RP-1:0]    r_en;
  logic [RP*AS-1:0] r_addr;
  logic [RP*WS-1:0] r_data;
  logic [RP-1:0]    r_ready;
`ifdef MEMORY_ADDR_CHECK_EN
  logic             addr_err;
`endif

  always #5 clock = ~clock;

  memory_multiport #(
    .WORD_SIZE(WS), .WORD_INIT(INIT), .ADDRESS_SIZE(AS), .MEMORY_QTY(QTY),
    .R_PORTS(RP), .WAIT_SIZE(WSZ), .READ_WAIT(RW), .WRITE_WAIT(WW)
  ) dut (
    .clock(clock), .reset(reset),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_ready(r_ready)
`ifdef MEMORY_ADDR_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  // Reference: plain array of words plus the last value each read port delivered.
  logic [WS-1:0] ref_mem [16];
  logic [WS-1:0] exp_rdata [RP];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WS-1:0] ref_read(input int unsigned a);
    return (a < QTY) ? ref_mem[a] : INIT;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_w_ready"}, 32'(w_ready), 32'd0);
    check_eq({tag, "_r_ready"}, 32'(r_ready), 32'd0);
    check_eq({tag, "_r_data"},  32'(r_data),  32'd0);
`ifdef MEMORY_ADDR_CHECK_EN
    check_eq({tag, "_addr_err"}, 32'(addr_err), 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    w_en  = 1'b0;
    r_en  = '0;
    #1;
    check_outputs_zero("reset");
    tick();
    tick();
    reset = 1'b1;
    for (int p = 0; p < RP; p++) exp_rdata[p] = '0;
  endtask

  task automatic check_rdata(input string tag);
    for (int p = 0; p < RP; p++)
      check_eq($sformatf("%s_rdata%0d", tag, p), 32'(r_data[p*WS +: WS]), 32'(exp_rdata[p]));
  endtask

  task automatic do_access(input bit wr, input int port, input logic [AS-1:0] a, input logic [WS-1:0] d);
    int  e;
    bit  seen;
    if (wr) begin
      w_addr = a;
      w_data = d;
      w_en   = 1'b1;
    end else begin
      r_addr[port*AS +: AS] = a;
      r_en[port] = 1'b1;
    end
    e = 0;
    seen = 1'b0;
    while (!seen && e < 40) begin
      tick();
      e++;
      seen = wr ? w_ready : r_ready[port];
    end
    check_eq(wr ? "w_ready_seen" : "r_ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      check_eq(wr ? "w_latency" : "r_latency", 32'(e - 1), 32'((wr ? WW : RW) + 2));
      if (wr) begin
        if (a < QTY) ref_mem[a] = d;
      end else begin
        exp_rdata[port] = ref_read(a);
      end
      check_rdata(wr ? "wr" : "rd");
`ifdef MEMORY_ADDR_CHECK_EN
      check_eq("addr_err", 32'(addr_err), 32'(a >= QTY));
`endif
    end
    w_en = 1'b0;
    r_en = '0;
    tick();
    check_eq("pulse_w_ready", 32'(w_ready), 32'd0);
    check_eq("pulse_r_ready", 32'(r_ready), 32'd0);
  endtask

  int exp_g [6];

  initial begin
    reset  = 1'b0;
    w_en   = 1'b0;
    w_addr = '0;
    w_data = '0;
    r_en   = '0;
    r_addr = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = INIT;
    do_reset();

    // Power-on content, basic write/read, out-of-range handling.
    do_access(1'b0, 0, 4'd0, '0);
    do_access(1'b1, 0, 4'd3, 8'hA5);
    do_access(1'b0, 0, 4'd3, '0);
    do_access(1'b1, 0, 4'd15, 8'h77);
    do_access(1'b0, 1, 4'd15, '0);
    for (int a = 0; a < QTY; a++) do_access(1'b0, 1, 4'(a), '0);

    // Holding en high after ready gives exactly one access; re-raising gives another.
    begin
      int pulses;
      r_addr[1*AS +: AS] = 4'd3;
      r_en[1] = 1'b1;
      pulses = 0;
      for (int c = 0; c < int'(RW) + 13; c++) begin
        tick();
        if (r_ready[1]) pulses++;
      end
      check_eq("hold_pulses", 32'(pulses), 32'd1);
      exp_rdata[1] = ref_read(3);
      check_rdata("hold");
      r_en[1] = 1'b0;
      tick();
      r_en[1] = 1'b1;
      pulses = 0;
      for (int c = 0; c < int'(RW) + 5; c++) begin
        tick();
        if (r_ready[1]) pulses++;
      end
      check_eq("rearm_pulses", 32'(pulses), 32'd1);
      r_en = '0;
      tick();
    end

    // Arbitration with every port requesting and re-raising one cycle after its ready.
    do_reset();
    begin
      int last_w, p, prev, g;
      logic [RP:0] drop;
      last_w = 0; p = 0; prev = -1;
      for (int i = 0; i < 6; i++) begin
        bit wpend, anyr;
        wpend = (prev != int'(RP));
        anyr  = (RP > 1) || (prev == int'(RP));
        if (wpend && !(last_w != 0 && anyr)) begin
          exp_g[i] = RP;
          last_w = 1;
        end else begin
          for (int k = 0; k < int'(RP); k++) begin
            int q;
            q = (p + k) % RP;
            if (q != prev) begin
              exp_g[i] = q;
              p = (q + 1) % RP;
              break;
            end
          end
          last_w = 0;
        end
        prev = exp_g[i];
      end

      w_addr = 4'd5;
      w_data = 8'(($urandom % 255) + 1);
      r_addr[0*AS +: AS] = 4'd5;
      r_addr[1*AS +: AS] = 4'd7;
      w_en = 1'b1;
      r_en = '1;
      drop = '0;
      g = 0;
      for (int c = 0; c < 300 && g < 6; c++) begin
        tick();
        if (drop[RP]) begin
          check_eq("arb_w_pulse", 32'(w_ready), 32'd0);
          w_en = 1'b1;
        end
        for (int q = 0; q < int'(RP); q++) begin
          if (drop[q]) begin
            check_eq($sformatf("arb_r%0d_pulse", q), 32'(r_ready[q]), 32'd0);
            r_en[q] = 1'b1;
          end
        end
        drop = '0;
        if (w_ready && g < 6) begin
          check_eq($sformatf("arb_grant%0d", g), 32'(RP), 32'(exp_g[g]));
          ref_mem[5] = w_data;
          w_en = 1'b0;
          drop[RP] = 1'b1;
          g++;
        end
        for (int q = 0; q < int'(RP); q++) begin
          if (r_ready[q] && g < 6) begin
            check_eq($sformatf("arb_grant%0d", g), 32'(q), 32'(exp_g[g]));
            check_eq($sformatf("arb_data%0d", g), 32'(r_data[q*WS +: WS]),
                     32'(ref_read(int'(r_addr[q*AS +: AS]))));
            r_en[q] = 1'b0;
            drop[q] = 1'b1;
            g++;
          end
        end
      end
      check_eq("arb_count", 32'(g), 32'd6);
      w_en = 1'b0;
      r_en = '0;
      tick();
      tick();
    end
    do_reset();

    // Reset during the wait states of a write aborts it.
    do_access(1'b1, 0, 4'd2, 8'h3C);
    w_addr = 4'd2;
    w_data = 8'hC3;
    w_en   = 1'b1;
    tick();
    tick();
    tick();
    check_eq("abort_no_ready", 32'(w_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_outputs_zero("abort_rst");
    w_en = 1'b0;
    tick();
    check_outputs_zero("abort_hold");
    reset = 1'b1;
    for (int p = 0; p < RP; p++) exp_rdata[p] = '0;
    tick();
    do_access(1'b0, 0, 4'd2, '0);

    // Random single transactions across ports and the full address range.
    for (int i = 0; i < 80; i++) begin
      bit wr;
      wr = ($urandom_range(0, 2) == 0);
      do_access(wr, int'($urandom_range(0, RP - 1)), 4'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_multiport.md
Name: memory_multiport

Overview:
Parametrised successor to the single read/write memory. One write port and R_PORTS independent read ports share a single-port storage array. Each request is serviced one at a time with programmable wait states and a per-port ready pulse. Sits between multiple iCE40 bus masters (CPU, display fetch, DMA) and an inferred block RAM.

Parameters:
WORD_SIZE, 8, data width in bits
WORD_INIT, 0, power-on content of every word; also the read value for out-of-range addresses
ADDRESS_SIZE, 4, address width in bits
MEMORY_QTY, 16, number of words; must be <= 2**ADDRESS_SIZE
R_PORTS, 2, number of read ports; 1..8
WAIT_SIZE, 2, width of the wait counters
READ_WAIT, 0, extra wait cycles per read; 0..2**WAIT_SIZE-1
WRITE_WAIT, 0, extra wait cycles per write; 0..2**WAIT_SIZE-1

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
w_en  in  1  write request; hold high until w_ready
w_addr  in  ADDRESS_SIZE  write address; stable while w_en high
w_data  in  WORD_SIZE  write data; stable while w_en high
w_ready  out  1  one-cycle pulse: write done
r_en  in  R_PORTS  per-port read request
r_addr  in  R_PORTS*ADDRESS_SIZE  packed read addresses; port i at bits [i*ADDRESS_SIZE +: ADDRESS_SIZE]
r_data  out  R_PORTS*WORD_SIZE  packed, registered read data per port
r_ready  out  R_PORTS  per-port one-cycle pulse: read data valid

Behaviour:
- reset low: FSM->IDLE; wait counter, w_ready, r_ready, r_data -> 0; round-robin pointer -> port 0; all "armed" flags set. Array contents are not cleared; they are initialised to WORD_INIT at configuration only, so block RAM is still inferred.
- Reset asserted mid-access aborts the access. A write that has not reached its ready edge does not modify the array.
- FSM states:
  - IDLE: if any armed request is pending, latch the grant, address and data; go to WAIT if the grant's wait count > 0, else to ACCESS.
  - WAIT: decrement the counter; go to ACCESS at 0.
  - ACCESS: perform the array operation; pulse ready for the granted port; return to IDLE.
- Latency: request sampled high at edge k in IDLE -> ready high during the cycle after edge k+2+WAIT. With 0 wait states, ready is high in the 2nd cycle after the request is sampled.
- Arbitration:
  - Write wins over reads, except when the previous grant was a write and any read is pending; then a read wins.
  - Reads are round-robin starting from pointer p; the pointer moves to (granted+1) mod R_PORTS.
- Per-port armed flag:
  - Cleared when that port's ready pulses.
  - Set again only when that port's en is sampled low.
  - Holding en high after ready never causes a second access.
- en dropped before ready: the access still completes and ready still pulses; the port re-arms on the next low sample.
- r_data[i] updates only on port i's ready edge and holds until port i's next completed read.
- Out-of-range address (>= MEMORY_QTY): write is discarded; read returns WORD_INIT; ready still pulses.
- Read of a word written earlier returns the new value. There is no same-cycle read/write because accesses are serialised.

Optional Feature:
MEMORY_ADDR_CHECK_EN
- Defined: adds output addr_err (1 bit, reset 0). It pulses together with w_ready/r_ready when the completed access had an address >= MEMORY_QTY.
- Undefined: no addr_err port. Out-of-range behaviour is otherwise identical.

Test Plan:
- Reset, then write 0xA5 to addr 3 with WRITE_WAIT=0 -> w_ready high exactly 2 cycles after w_en sampled. Then read port 0 addr 3 -> r_data[7:0]=0xA5 with r_ready[0] pulse.
- READ_WAIT=3, read addr 0 after reset -> r_ready[0] appears 5 cycles after r_en sampled; r_data=WORD_INIT.
- r_en=2'b11 and w_en all held high with re-raise after ready, pointer=0 -> grant order W, R0, W, R1, W, R0. Each ready is one cycle; no port starves.
- Hold r_en[1] high for 10 cycles after r_ready[1] -> exactly one r_ready[1] pulse. Drop and re-raise -> a second pulse.
- Write addr 15 with MEMORY_QTY=12 -> w_ready pulses and no word changes. Read addr 15 -> WORD_INIT. With MEMORY_ADDR_CHECK_EN, addr_err pulses both times.
- Assert reset during WAIT of a write to addr 2 (WRITE_WAIT=3) -> no w_ready; a later read of addr 2 returns the previous value. All outputs are 0 during reset.
